// File: rtl/tmem_pkg.sv
// tmem_pkg: shared types and constants for the tagged wait-state memory model.
//   tmem_state_t  - controller FSM states
//   TMEM_MAX_WAIT - largest supported RD_WAIT / WR_WAIT value
//   TMEM_CNT_W    - wait counter width, sized to hold TMEM_MAX_WAIT
package tmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RWAIT  = 2'd1,
        WWAIT  = 2'd2,
        LOCKED = 2'd3
    } tmem_state_t;

    localparam int TMEM_MAX_WAIT = 15;
    localparam int TMEM_CNT_W    = $clog2(TMEM_MAX_WAIT + 1);

endpackage

// File: rtl/tmem_array.sv
// tmem_array: 2**AW x (DW+TW) storage for the tagged memory model.
//   clk            - write clock
//   we             - write enable, commits {wtag, wdata} to mem[waddr]
//   waddr/wdata/wtag - write port
//   raddr          - asynchronous read address
//   rdata/rtag     - read port
// Each word is stored as {tag, data}. The array is never reset so that
// testbench loaders can preload `mem` hierarchically.
module tmem_array
    import tmem_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 64,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [TW-1:0] wtag,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic [TW-1:0] rtag
);

    logic [TW+DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {wtag, wdata};
        end
    end

    assign {rtag, rdata} = mem[raddr];

endmodule

// File: rtl/tmemory_wait.sv
// tmemory_wait: tagged main-memory model with wait states, ready handshake,
// atomic read-modify-write locking and protocol-error reporting.
//   clk, reset       - single clock, synchronous active-high reset
//   i_ad             - address (low AW bits) with i_astb, write data with i_wr
//   i_tag            - write tag
//   i_astb           - address strobe; i_atomic with it starts an RMW sequence
//   i_rd, i_wr       - read / write requests
//   o_data, o_tag    - read result, held until the next read completes
//   o_rdy            - one-cycle completion pulse (read or write)
//   o_busy           - read or write in flight
//   o_err            - one-cycle protocol-violation pulse (registered)
//   o_waddr          - latched word address
module tmemory_wait
    import tmem_pkg::*;
#(
    parameter int AW      = 20,
    parameter int DW      = 64,
    parameter int TW      = 8,
    parameter int RD_WAIT = 0,
    parameter int WR_WAIT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] i_ad,
    input  logic [TW-1:0] i_tag,
    input  logic          i_astb,
    input  logic          i_atomic,
    input  logic          i_rd,
    input  logic          i_wr,
    output logic [DW-1:0] o_data,
    output logic [TW-1:0] o_tag,
    output logic          o_rdy,
    output logic          o_busy,
    output logic          o_err,
    output logic [AW-1:0] o_waddr
);

    localparam logic [TMEM_CNT_W-1:0] RD_CNT = TMEM_CNT_W'(RD_WAIT);
    localparam logic [TMEM_CNT_W-1:0] WR_CNT = TMEM_CNT_W'(WR_WAIT);

    tmem_state_t           state, state_nxt;
    logic [TMEM_CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]         waddr, waddr_nxt;
    logic                  lock_req, lock_nxt;
    logic [DW-1:0]         wbuf_data;
    logic [TW-1:0]         wbuf_tag;
    logic                  wbuf_ld;
    logic                  mem_we;
    logic                  rd_done;
    logic                  err_nxt;
    logic [DW-1:0]         arr_data;
    logic [TW-1:0]         arr_tag;

    // Writes commit on the same edge that raises o_rdy, so a read issued
    // in the o_rdy cycle already sees the new word.
    tmem_array #(.AW(AW), .DW(DW), .TW(TW)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr),
        .wdata (wbuf_data),
        .wtag  (wbuf_tag),
        .raddr (waddr),
        .rdata (arr_data),
        .rtag  (arr_tag)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        waddr_nxt = waddr;
        lock_nxt  = lock_req;
        wbuf_ld   = 1'b0;
        mem_we    = 1'b0;
        rd_done   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE, LOCKED: begin
                // Any illegal combination is dropped whole: no address
                // latch, no request.  In LOCKED only a plain write is legal.
                if ((i_astb && i_wr) || (i_rd && i_wr) ||
                    (state == LOCKED && (i_astb || i_rd))) begin
                    err_nxt = 1'b1;
                end else begin
                    if (i_astb) begin
                        waddr_nxt = i_ad[AW-1:0];
                        lock_nxt  = i_atomic;
                    end
                    if (i_rd) begin
                        state_nxt = RWAIT;
                        cnt_nxt   = RD_CNT;
                    end else if (i_wr) begin
                        wbuf_ld   = 1'b1;
                        state_nxt = WWAIT;
                        cnt_nxt   = WR_CNT;
                        if (state == LOCKED) begin
                            lock_nxt = 1'b0;
                        end
                    end
                end
            end
            RWAIT: begin
                err_nxt = i_astb || i_rd || i_wr;
                if (cnt == '0) begin
                    rd_done   = 1'b1;
                    state_nxt = lock_req ? LOCKED : IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WWAIT: begin
                err_nxt = i_astb || i_rd || i_wr;
                if (cnt == '0) begin
                    mem_we    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            waddr     <= '0;
            lock_req  <= 1'b0;
            wbuf_data <= '0;
            wbuf_tag  <= '0;
            o_data    <= '0;
            o_tag     <= '0;
            o_rdy     <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            waddr    <= waddr_nxt;
            lock_req <= lock_nxt;
            o_rdy    <= rd_done || mem_we;
            o_err    <= err_nxt;
            if (wbuf_ld) begin
                wbuf_data <= i_ad;
                wbuf_tag  <= i_tag;
            end
            if (rd_done) begin
                o_data <= arr_data;
                o_tag  <= arr_tag;
            end
        end
    end

    assign o_busy  = (state == RWAIT) || (state == WWAIT);
    assign o_waddr = waddr;

endmodule

// File: tb/tb_tmemory_wait.sv
// tb_tmemory_wait: scoreboard bench for tmemory_wait.
// Three instances with different wait settings share clock and reset:
//   0: RD_WAIT=3 WR_WAIT=2   1: RD_WAIT=0 WR_WAIT=0   2: RD_WAIT=1 WR_WAIT=4
// Each request pushes its expected completion cycle (and read data) into a
// queue; a monitor pops and compares whenever any o_rdy is seen.
module tb_tmemory_wait;

    localparam int ND = 3;
    localparam int AW = 10;
    localparam int RW [ND] = '{3, 0, 1};
    localparam int WW [ND] = '{2, 0, 4};

    // control code {astb, atomic, rd, wr}
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_AS   = 4'b1000;
    localparam logic [3:0] C_AT   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0010;
    localparam logic [3:0] C_WR   = 4'b0001;

    logic          clk = 1'b0;
    logic          reset;
    logic          astb [ND];
    logic          atomic [ND];
    logic          rd [ND];
    logic          wr [ND];
    logic [63:0]   ad [ND];
    logic [7:0]    tag_i [ND];
    logic [63:0]   data [ND];
    logic [7:0]    tag_o [ND];
    logic          rdy [ND];
    logic          busy [ND];
    logic          err [ND];
    logic [AW-1:0] waddr [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        tmemory_wait #(
            .AW(AW), .DW(64), .TW(8), .RD_WAIT(RW[g]), .WR_WAIT(WW[g])
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .i_ad     (ad[g]),
            .i_tag    (tag_i[g]),
            .i_astb   (astb[g]),
            .i_atomic (atomic[g]),
            .i_rd     (rd[g]),
            .i_wr     (wr[g]),
            .o_data   (data[g]),
            .o_tag    (tag_o[g]),
            .o_rdy    (rdy[g]),
            .o_busy   (busy[g]),
            .o_err    (err[g]),
            .o_waddr  (waddr[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          dev;
        bit          is_rd;
        logic [63:0] data;
        logic [7:0]  tag;
        int          due;
    } sb_t;

    sb_t sbq [$];
    sb_t mit;
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called at a negedge just before the step that issues the request.
    task automatic push(input int d, input bit is_rd, input logic [63:0] dv, input logic [7:0] tv);
        sb_t it;
        it.dev   = d;
        it.is_rd = is_rd;
        it.data  = dv;
        it.tag   = tv;
        it.due   = cyc + 2 + (is_rd ? RW[d] : WW[d]);
        sbq.push_back(it);
    endtask

    // Drive one cycle on instance d, then check o_err after the edge.
    task automatic step(input int d, input logic [3:0] c, input logic [63:0] adv,
                        input logic [7:0] tv, input logic e);
        {astb[d], atomic[d], rd[d], wr[d]} = c;
        ad[d]    = adv;
        tag_i[d] = tv;
        @(posedge clk);
        @(negedge clk);
        {astb[d], atomic[d], rd[d], wr[d]} = C_NONE;
        chk("err", 72'(err[d]), 72'(e));
    endtask

    task automatic idle(input int d);
        step(d, C_NONE, 64'd0, 8'd0, 1'b0);
    endtask

    task automatic drain(input int d);
        int i = 0;
        while ((sbq.size() != 0 || busy[d]) && i < 40) begin
            idle(d);
            i++;
        end
        chk("drain", 72'(sbq.size()), 72'd0);
    endtask

    task automatic bus_wr(input int d, input logic [63:0] a, input logic [63:0] dv, input logic [7:0] tv);
        step(d, C_AS, a, 8'd0, 1'b0);
        push(d, 1'b0, dv, tv);
        step(d, C_WR, dv, tv, 1'b0);
        drain(d);
    endtask

    task automatic bus_rd(input int d, input logic [63:0] a, input logic [63:0] dv, input logic [7:0] tv);
        push(d, 1'b1, dv, tv);
        step(d, C_AS | C_RD, a, 8'd0, 1'b0);
        drain(d);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_data",  72'(data[d]),  72'd0);
        chk("rst_tag",   72'(tag_o[d]), 72'd0);
        chk("rst_rdy",   72'(rdy[d]),   72'd0);
        chk("rst_busy",  72'(busy[d]),  72'd0);
        chk("rst_err",   72'(err[d]),   72'd0);
        chk("rst_waddr", 72'(waddr[d]), 72'd0);
    endtask

    function automatic logic [63:0] pat(input int a);
        return {32'(a) ^ 32'hA5A5_0000, ~32'(a)};
    endfunction

    function automatic logic [7:0] ptag(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rdy[d] === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("rdy_unexpected", 72'(rdy[d]), 72'd0);
                end else begin
                    mit = sbq.pop_front();
                    chk("sb_dev", 72'(d), 72'(mit.dev));
                    chk("sb_latency", 72'(cyc), 72'(mit.due));
                    if (mit.is_rd) begin
                        chk("rd_data", 72'(data[d]), 72'(mit.data));
                        chk("rd_tag",  72'(tag_o[d]), 72'(mit.tag));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            {astb[d], atomic[d], rd[d], wr[d]} = C_NONE;
            ad[d]    = 64'd0;
            tag_i[d] = 8'd0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk_reset(d);
        reset = 1'b0;

        // ---- instance 0: read with RD_WAIT=3, busy window ----
        bus_wr(0, 64'd5, 64'h0123456789ABCDEF, 8'h3C);
        push(0, 1'b1, 64'h0123456789ABCDEF, 8'h3C);
        step(0, C_AS | C_RD, 64'd5, 8'd0, 1'b0);
        chk("rd_busy_start", 72'(busy[0]), 72'd1);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("rd_busy_wait", 72'(busy[0]), 72'd1);
        end
        idle(0);
        chk("rd_busy_end", 72'(busy[0]), 72'd0);

        // ---- write WR_WAIT=2, read issued in the o_rdy cycle ----
        step(0, C_AS, 64'd7, 8'd0, 1'b0);
        push(0, 1'b0, 64'hDEAD, 8'h01);
        step(0, C_WR, 64'hDEAD, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) idle(0);
        chk("wr_rdy_cycle", 72'(rdy[0]), 72'd1);
        push(0, 1'b1, 64'hDEAD, 8'h01);
        step(0, C_AS | C_RD, 64'd7, 8'd0, 1'b0);
        drain(0);

        // ---- protocol errors ----
        step(0, C_AS | C_WR, 64'd5, 8'd0, 1'b1);
        chk("astb_wr_ignored", 72'(waddr[0]), 72'd7);
        step(0, C_RD | C_WR, 64'd0, 8'd0, 1'b1);
        idle(0);
        push(0, 1'b1, 64'hDEAD, 8'h01);
        step(0, C_AS | C_RD, 64'd7, 8'd0, 1'b0);
        step(0, C_RD, 64'd0, 8'd0, 1'b1);
        step(0, C_WR, 64'd5, 8'd0, 1'b1);
        step(0, C_AS, 64'd9, 8'd0, 1'b1);
        drain(0);
        chk("busy_astb_ignored", 72'(waddr[0]), 72'd7);

        // ---- atomic read-modify-write ----
        bus_wr(0, 64'd9, 64'h99, 8'h09);
        bus_rd(0, 64'd9, 64'h99, 8'h09);
        push(0, 1'b1, 64'h99, 8'h09);
        step(0, C_AS | C_AT | C_RD, 64'd9, 8'd0, 1'b0);
        drain(0);
        step(0, C_AS, 64'd10, 8'd0, 1'b1);
        chk("locked_waddr", 72'(waddr[0]), 72'd9);
        step(0, C_RD, 64'd0, 8'd0, 1'b1);
        push(0, 1'b0, 64'h5, 8'h00);
        step(0, C_WR, 64'h5, 8'h00, 1'b0);
        drain(0);
        chk("locked_mem", g_dut[0].u_dut.u_array.mem[9], {8'h00, 64'h5});
        push(0, 1'b1, 64'h5, 8'h00);
        step(0, C_RD, 64'd0, 8'd0, 1'b0);
        drain(0);
        step(0, C_AS, 64'd10, 8'd0, 1'b0);
        chk("unlocked_waddr", 72'(waddr[0]), 72'd10);

        // ---- instance 1: zero-wait back-to-back sweep ----
        for (int a = 0; a < 256; a++) begin
            step(1, C_AS, 64'(a), 8'd0, 1'b0);
            push(1, 1'b0, pat(a), ptag(a));
            step(1, C_WR, pat(a), ptag(a), 1'b0);
            idle(1);
        end
        for (int a = 0; a < 256; a++) begin
            push(1, 1'b1, pat(a), ptag(a));
            step(1, C_AS | C_RD, 64'(a), 8'd0, 1'b0);
            idle(1);
        end
        drain(1);

        // ---- instance 2: reset one cycle into a WR_WAIT=4 write ----
        bus_wr(2, 64'd3, 64'h33, 8'h03);
        bus_rd(2, 64'd3, 64'h33, 8'h03);
        step(2, C_AS, 64'd3, 8'd0, 1'b0);
        step(2, C_WR, 64'hFF, 8'hFF, 1'b0);
        idle(2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < ND; d++) chk_reset(d);
        for (int i = 0; i < 6; i++) idle(2);
        chk("abort_mem", g_dut[2].u_dut.u_array.mem[3], {8'h03, 64'h33});
        bus_rd(2, 64'd3, 64'h33, 8'h03);

        chk("sb_empty", 72'(sbq.size()), 72'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
